// File: rtl/csi2_packet_parser.sv
// csi2_packet_parser: splits the 2-lane CSI-2 word stream into packets, checks header ECC and
// payload CRC-16, and forwards DT_RAW long-packet payload words on VC_SEL to the byte-to-pixel stage.
module csi2_packet_parser #(
   parameter logic [5:0] DT_RAW    = 6'h2B,
   parameter logic [1:0] VC_SEL    = 2'd0,
   parameter bit         CRC_CHECK = 1'b1
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic        byte_vld,
   input  logic [15:0] byte_data,
   input  logic        byte_sot,
   output logic        raw_vld,
   output logic [15:0] raw_data,
   output logic        raw_vsync,
   output logic        frame_end,
   output logic        line_start,
   output logic [15:0] line_wc,
   output logic        ecc_err,
   output logic        crc_err
);
   typedef enum logic [2:0] {IDLE, HDR1, PAYLOAD, CRC, DROP} state_t;
   state_t      state_q;
   logic [15:0] h0_q, cnt_q, crc_q, raw_data_q, line_wc_q;
   logic        raw_vld_q, vsync_q, fe_q, ls_q, ecc_err_q, crc_err_q;
   logic [15:0] crc_d, wc, cnt_up;
   logic [23:0] hdr;
   logic [7:0]  di, ecc;
   logic        hdr_ok;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      return r;
   endfunction

   // Header ECC: each parity bit is the XOR of a fixed subset of the 24 {WC,DI} bits
   always_comb begin
      hdr    = {byte_data[7:0], h0_q};
      di     = h0_q[7:0];
      wc     = {byte_data[7:0], h0_q[15:8]};
      ecc    = {2'b00, ^(hdr & 24'hEFFC00), ^(hdr & 24'hDF03F0), ^(hdr & 24'hB8E38E),
                       ^(hdr & 24'h749A6D), ^(hdr & 24'hF2555B), ^(hdr & 24'hF12CB7)};
      hdr_ok = byte_data[15:8] == ecc;
      cnt_up = {1'b0, wc[15:1]} + {15'd0, wc[0]};
      crc_d  = crc_byte(crc_byte(crc_q, byte_data[7:0]), byte_data[15:8]);
   end

   always_ff @(posedge sclk or negedge s_rst_n)
      if (!s_rst_n) begin
         state_q    <= IDLE;
         h0_q       <= '0;
         cnt_q      <= '0;
         crc_q      <= '0;
         raw_vld_q  <= 1'b0;
         raw_data_q <= '0;
         vsync_q    <= 1'b0;
         fe_q       <= 1'b0;
         ls_q       <= 1'b0;
         line_wc_q  <= '0;
         ecc_err_q  <= 1'b0;
         crc_err_q  <= 1'b0;
      end else begin
         raw_vld_q <= 1'b0;
         vsync_q   <= 1'b0;
         fe_q      <= 1'b0;
         ls_q      <= 1'b0;
         ecc_err_q <= 1'b0;
         crc_err_q <= 1'b0;
         if (byte_vld && byte_sot) begin
            h0_q    <= byte_data;
            state_q <= HDR1;
         end else if (byte_vld) begin
            case (state_q)
               HDR1: begin
                  state_q <= IDLE;
                  cnt_q   <= cnt_up;
                  crc_q   <= 16'hFFFF;
                  if (!hdr_ok)
                     ecc_err_q <= 1'b1;
                  else if (di[7:6] != VC_SEL)
                     state_q <= (di[5:4] == 2'b00) ? IDLE : DROP;
                  else if (di[5:4] == 2'b00) begin
                     vsync_q <= di[5:0] == 6'h00;
                     fe_q    <= di[5:0] == 6'h01;
                  end else if (di[5:0] != DT_RAW)
                     state_q <= DROP;
                  else if (!wc[0] && wc != 16'd0) begin
                     ls_q      <= 1'b1;
                     line_wc_q <= wc;
                     state_q   <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  raw_vld_q  <= 1'b1;
                  raw_data_q <= byte_data;
                  crc_q      <= crc_d;
                  cnt_q      <= cnt_q - 16'd1;
                  if (cnt_q == 16'd1) state_q <= CRC;
               end
               CRC: begin
                  crc_err_q <= CRC_CHECK && (byte_data != crc_q);
                  state_q   <= IDLE;
               end
               DROP: begin
                  cnt_q <= cnt_q - 16'd1;
                  if (cnt_q == 16'd0) state_q <= IDLE;
               end
               default: ;
            endcase
         end
      end

   assign raw_vld    = raw_vld_q;
   assign raw_data   = raw_data_q;
   assign raw_vsync  = vsync_q;
   assign frame_end  = fe_q;
   assign line_start = ls_q;
   assign line_wc    = line_wc_q;
   assign ecc_err    = ecc_err_q;
   assign crc_err    = crc_err_q;
endmodule

// File: tb/tb_csi2_packet_parser.sv
// tb_csi2_packet_parser: packets are turned into a per-cycle table of {inputs, expected outputs}
// by a packet-level model, then replayed against the parser; plus a hand-written mid-packet reset.
module tb_csi2_packet_parser;
   localparam logic [5:0] COL [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                                       6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                                       6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
   logic        sclk = 1'b0, s_rst_n = 1'b0, byte_vld = 1'b0, byte_sot = 1'b0;
   logic [15:0] byte_data = '0;
   logic        raw_vld, raw_vsync, frame_end, line_start, ecc_err, crc_err;
   logic [15:0] raw_data, line_wc;
   int          n_tests = 0, n_fail = 0, gap_mode = 0, pkt_id = 0;
   logic [15:0] m_wc = '0;

   typedef struct {
      logic        vld, sot;
      logic [15:0] data;
      logic        rv, vs, fe, ls, ee, ce;
      logic [15:0] wc;
      int          pkt;
   } vec_t;
   vec_t tbl[$];

   csi2_packet_parser dut (
      .sclk(sclk), .s_rst_n(s_rst_n), .byte_vld(byte_vld), .byte_data(byte_data),
      .byte_sot(byte_sot), .raw_vld(raw_vld), .raw_data(raw_data), .raw_vsync(raw_vsync),
      .frame_end(frame_end), .line_start(line_start), .line_wc(line_wc),
      .ecc_err(ecc_err), .crc_err(crc_err)
   );

   always #5 sclk = ~sclk;

   // Hamming syndrome: XOR of the column code of every set data bit
   function automatic logic [7:0] ecc8(input logic [23:0] d);
      logic [5:0] s = '0;
      for (int i = 0; i < 24; i++)
         if (d[i]) s ^= COL[i];
      return {2'b00, s};
   endfunction

   // Bit-serial CRC: lane0 byte then lane1 byte, each LSB first
   function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] w);
      logic fb;
      for (int i = 0; i < 16; i++) begin
         fb = c[0] ^ w[i];
         c  = c >> 1;
         if (fb) c ^= 16'h8408;
      end
      return c;
   endfunction

   task automatic push(input logic vld, input logic sot, input logic [15:0] d,
                       input logic rv, input logic vs, input logic fe, input logic ls,
                       input logic ee, input logic ce);
      vec_t v;
      v.vld = vld; v.sot = sot; v.data = d;
      v.rv = rv; v.vs = vs; v.fe = fe; v.ls = ls; v.ee = ee; v.ce = ce;
      v.wc = m_wc; v.pkt = pkt_id;
      tbl.push_back(v);
   endtask

   task automatic gaps();
      int g;
      g = (gap_mode == 1) ? 1 : (gap_mode == 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      repeat (g) push(1'b0, 1'($urandom), 16'($urandom), 0, 0, 0, 0, 0, 0);
   endtask

   task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input int flip,
                           input bit bad_crc, input int stop, input bit seq);
      logic [7:0]  e;
      logic [15:0] crc, w;
      bit          ok, vcm, fwd;
      int          n;
      pkt_id++;
      e = ecc8({wc, di});
      ok = flip < 0;
      if (!ok) e[flip] = ~e[flip];
      vcm = di[7:6] == 2'd0;
      fwd = ok && vcm && di[5:0] == 6'h2B && wc != 0 && !wc[0];
      gaps();
      push(1, 1, {wc[7:0], di}, 0, 0, 0, 0, 0, 0);
      gaps();
      if (fwd) m_wc = wc;
      push(1, 0, {e, wc[15:8]}, 0, ok && vcm && di[5:0] == 6'h00, ok && vcm && di[5:0] == 6'h01,
           fwd, !ok, 0);
      if (di[5:0] < 6'h10) return;
      n = (int'(wc) + 1) / 2;
      crc = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         if (i == stop) return;
         w = seq ? {8'(i + 1), 8'(i)} : 16'($urandom);
         crc = crc_word(crc, w);
         gaps();
         push(1, 0, w, fwd, 0, 0, 0, 0, 0);
      end
      gaps();
      push(1, 0, crc ^ {15'd0, bad_crc}, 0, 0, 0, 0, 0, fwd && bad_crc);
   endtask

   task automatic run_tbl();
      vec_t v;
      while (tbl.size() > 0) begin
         v = tbl.pop_front();
         byte_vld = v.vld; byte_sot = v.sot; byte_data = v.data;
         @(posedge sclk); #1;
         n_tests++;
         if ({raw_vld, raw_vsync, frame_end, line_start, ecc_err, crc_err, line_wc} !==
             {v.rv, v.vs, v.fe, v.ls, v.ee, v.ce, v.wc} || (v.rv && raw_data !== v.data)) begin
            n_fail++;
            $display("FAIL pkt%0d step: got rv=%b vs=%b fe=%b ls=%b ee=%b ce=%b wc=%h rd=%h, expected rv=%b vs=%b fe=%b ls=%b ee=%b ce=%b wc=%h rd=%h",
                     v.pkt, raw_vld, raw_vsync, frame_end, line_start, ecc_err, crc_err, line_wc, raw_data,
                     v.rv, v.vs, v.fe, v.ls, v.ee, v.ce, v.wc, v.data);
         end
      end
      byte_vld = 1'b0; byte_sot = 1'b0;
   endtask

   task automatic check_zero(input string name);
      n_tests++;
      if ({raw_vld, raw_data, raw_vsync, frame_end, line_start, line_wc, ecc_err, crc_err} !== '0) begin
         n_fail++;
         $display("FAIL %s: got rv=%b rd=%h vs=%b fe=%b ls=%b wc=%h ee=%b ce=%b, expected all 0",
                  name, raw_vld, raw_data, raw_vsync, frame_end, line_start, line_wc, ecc_err, crc_err);
      end
   endtask

   initial begin
      int k;
      logic [15:0] wc;
      repeat (3) @(posedge sclk);
      #1 check_zero("reset");
      s_rst_n = 1'b1;
      send_pkt(8'h00, 16'd0, -1, 0, -1, 0);
      send_pkt(8'h2B, 16'd10, -1, 0, -1, 1);
      send_pkt(8'h2B, 16'd10, 0, 0, -1, 1);
      send_pkt(8'h00, 16'd0, -1, 0, -1, 0);
      send_pkt(8'h2B, 16'd10, -1, 1, -1, 1);
      gap_mode = 1;
      send_pkt(8'h2B, 16'd10, -1, 0, -1, 1);
      gap_mode = 0;
      send_pkt(8'h2B, 16'd12, -1, 0, 3, 1);
      send_pkt(8'h01, 16'd0, -1, 0, -1, 0);
      send_pkt(8'h6B, 16'd10, -1, 0, -1, 1);
      send_pkt(8'h2B, 16'd7, -1, 0, -1, 1);
      send_pkt(8'h2B, 16'd0, -1, 0, -1, 1);
      send_pkt(8'h12, 16'd5, -1, 0, -1, 0);
      send_pkt(8'h40, 16'd0, -1, 0, -1, 0);
      send_pkt(8'h00, 16'd0, -1, 0, -1, 0);
      run_tbl();
      gap_mode = 2;
      repeat (150) begin
         k = $urandom_range(0, 9);
         wc = 16'(2 * $urandom_range(1, 20));
         case (k)
            0: send_pkt(8'h00, 16'($urandom), -1, 0, -1, 0);
            1: send_pkt(8'h01, 16'($urandom), -1, 0, -1, 0);
            2: send_pkt(8'h2B, wc, -1, 0, -1, 0);
            3: send_pkt(8'h2B, wc, -1, 1, -1, 0);
            4: send_pkt(8'h2B, wc, $urandom_range(0, 7), 0, -1, 0);
            5: send_pkt({2'($urandom_range(1, 3)), 6'h2B}, wc, -1, 0, -1, 0);
            6: send_pkt({2'($urandom_range(0, 3)), 6'($urandom_range(16, 63))}, 16'($urandom_range(0, 41)), -1, 0, -1, 0);
            7: send_pkt(8'h2B, wc + 16'd1, -1, 0, -1, 0);
            8: send_pkt({2'($urandom_range(0, 3)), 6'($urandom_range(0, 15))}, 16'($urandom), -1, 0, -1, 0);
            default: send_pkt(8'h2B, wc, -1, 0, $urandom_range(0, int'(wc) / 2 - 1), 0);
         endcase
      end
      run_tbl();
      gap_mode = 0;
      send_pkt(8'h2B, 16'd10, -1, 0, 2, 1);
      run_tbl();
      byte_vld = 1'b1; byte_data = 16'hABCD;
      @(posedge sclk); #1;
      n_tests++;
      if (raw_vld !== 1'b1 || raw_data !== 16'hABCD) begin
         n_fail++;
         $display("FAIL pre_reset_word: got rv=%b rd=%h, expected rv=1 rd=abcd", raw_vld, raw_data);
      end
      #2 s_rst_n = 1'b0;
      #1 check_zero("async_reset");
      @(posedge sclk); #1;
      s_rst_n = 1'b1; byte_vld = 1'b0;
      m_wc = '0;
      push(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
      send_pkt(8'h00, 16'd0, -1, 0, -1, 0);
      run_tbl();
      repeat (2) @(posedge sclk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
